// File: rtl/jt12_mixn_pkg.sv
// jt12_mixn shared types and arithmetic helpers.
// Optional clip flags in the mixer are enabled by JT12_MIXN_CLIP_EN.
package jt12_mixn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } state_t;

  function automatic int unity_f(input int gw);
    return 1 << (gw - 1);
  endfunction

  function automatic int aw_f(input int w, input int gw, input int ch);
    return w + gw + 1 + $clog2(ch);
  endfunction

  function automatic logic signed [63:0] sat_f(
    input logic signed [63:0] v,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jt12_mixn_sat.sv
// Gain-normalising shift and output saturation for one stereo side.
// Clip detection exists only when JT12_MIXN_CLIP_EN is defined.
module jt12_mixn_sat
  import jt12_mixn_pkg::*;
#(
  parameter int AW = 27,
  parameter int GW = 8,
  parameter int OW = 16
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [OW-1:0] y
`ifdef JT12_MIXN_CLIP_EN
  ,
  output logic                 clip
`endif
);

  logic signed [AW-1:0] sh;
  logic signed [63:0]   ext;
  logic signed [63:0]   lim;

  // floor-shift out the unity gain scale, then clamp to output range
  always_comb begin
    sh  = acc >>> (GW - 1);
    ext = 64'(sh);
    lim = sat_f(ext, OW);
    y   = OW'(lim);
  end

`ifdef JT12_MIXN_CLIP_EN
  assign clip = (lim != ext);
`endif

endmodule

// File: rtl/jt12_mixn.sv
// N-channel stereo mixer: per-channel gain, shared MAC, saturated output.
// Define JT12_MIXN_CLIP_EN to add sticky clip_left/clip_right flags.
module jt12_mixn
  import jt12_mixn_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 16,
  parameter int GW = 8,
  parameter int OW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic [CH*W-1:0]         left_in,
  input  logic [CH*W-1:0]         right_in,
  input  logic                    sample_in,
  input  logic                    gain_wr,
  input  logic [$clog2(CH)-1:0]   gain_addr,
  input  logic [GW-1:0]           gain_din,
  input  logic                    ovr_clr,
  output logic signed [OW-1:0]    snd_left,
  output logic signed [OW-1:0]    snd_right,
  output logic                    snd_sample,
  output logic                    busy,
  output logic                    overrun
`ifdef JT12_MIXN_CLIP_EN
  ,
  output logic                    clip_left,
  output logic                    clip_right
`endif
);

  localparam int AW = aw_f(W, GW, CH);
  localparam int IW = $clog2(CH);
  localparam int PW = W + GW + 1;
  localparam logic [GW-1:0] UNITY = GW'(unity_f(GW));
  localparam logic [IW:0]   NCH   = (IW + 1)'(CH);
  localparam logic [IW-1:0] LAST  = IW'(CH - 1);

  state_t               st;
  logic [IW-1:0]        idx;
  logic signed [AW-1:0] acc_l;
  logic signed [AW-1:0] acc_r;
  logic [GW-1:0]        gain   [CH];
  logic [GW-1:0]        gain_s [CH];
  logic signed [W-1:0]  left_s [CH];
  logic signed [W-1:0]  right_s[CH];
  logic signed [PW-1:0] prod_l;
  logic signed [PW-1:0] prod_r;
  logic signed [OW-1:0] sat_l;
  logic signed [OW-1:0] sat_r;
`ifdef JT12_MIXN_CLIP_EN
  logic                 clp_l;
  logic                 clp_r;
`endif

  // one shared signed-by-unsigned product per side for the current channel
  always_comb begin
    prod_l = left_s[idx]  * $signed({1'b0, gain_s[idx]});
    prod_r = right_s[idx] * $signed({1'b0, gain_s[idx]});
  end

  jt12_mixn_sat #(.AW(AW), .GW(GW), .OW(OW)) u_sat_l (
    .acc  (acc_l),
    .y    (sat_l)
`ifdef JT12_MIXN_CLIP_EN
    ,
    .clip (clp_l)
`endif
  );

  jt12_mixn_sat #(.AW(AW), .GW(GW), .OW(OW)) u_sat_r (
    .acc  (acc_r),
    .y    (sat_r)
`ifdef JT12_MIXN_CLIP_EN
    ,
    .clip (clp_r)
`endif
  );

  // gain bank, overrun flag and the IDLE/ACC/SAT mix sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      idx        <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      snd_left   <= '0;
      snd_right  <= '0;
      snd_sample <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        gain[k]    <= UNITY;
        gain_s[k]  <= UNITY;
        left_s[k]  <= '0;
        right_s[k] <= '0;
      end
`ifdef JT12_MIXN_CLIP_EN
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
`endif
    end else begin
      snd_sample <= 1'b0;
      if (gain_wr && ({1'b0, gain_addr} < NCH))
        gain[gain_addr] <= gain_din;
      if (ovr_clr)
        overrun <= 1'b0;
      if (cen && sample_in && busy)
        overrun <= 1'b1;
`ifdef JT12_MIXN_CLIP_EN
      if (ovr_clr) begin
        clip_left  <= 1'b0;
        clip_right <= 1'b0;
      end
`endif
      if (cen) begin
        case (st)
          IDLE: begin
            if (sample_in) begin
              for (int k = 0; k < CH; k++) begin
                left_s[k]  <= left_in[k*W +: W];
                right_s[k] <= right_in[k*W +: W];
                gain_s[k]  <= gain[k];
              end
              acc_l <= '0;
              acc_r <= '0;
              idx   <= '0;
              busy  <= 1'b1;
              st    <= ACC;
            end
          end
          ACC: begin
            acc_l <= acc_l + AW'(prod_l);
            acc_r <= acc_r + AW'(prod_r);
            idx   <= idx + 1'b1;
            if (idx == LAST)
              st <= SAT;
          end
          SAT: begin
            snd_left   <= sat_l;
            snd_right  <= sat_r;
            snd_sample <= 1'b1;
            busy       <= 1'b0;
            st         <= IDLE;
`ifdef JT12_MIXN_CLIP_EN
            if (clp_l) clip_left  <= 1'b1;
            if (clp_r) clip_right <= 1'b1;
`endif
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt12_mixn.sv
// Self-checking bench for jt12_mixn (CH=4 main instance, CH=3 side instance).
// Clip flag checks are compiled in when JT12_MIXN_CLIP_EN is defined.
module tb_jt12_mixn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, cen, sample_in, gain_wr, ovr_clr;
  logic [63:0]        left_in, right_in;
  logic [1:0]         gain_addr;
  logic [7:0]         gain_din;
  logic signed [15:0] snd_left, snd_right;
  logic               snd_sample, busy, overrun;
`ifdef JT12_MIXN_CLIP_EN
  logic               clip_left, clip_right;
`endif

  logic               b_cen, b_sample_in, b_gain_wr, b_ovr_clr;
  logic [47:0]        b_left_in, b_right_in;
  logic [1:0]         b_gain_addr;
  logic [7:0]         b_gain_din;
  logic signed [15:0] b_snd_left, b_snd_right;
  logic               b_snd_sample, b_busy, b_overrun;
`ifdef JT12_MIXN_CLIP_EN
  logic               b_clip_left, b_clip_right;
`endif

  jt12_mixn #(.CH(4), .W(16), .GW(8), .OW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .left_in    (left_in),
    .right_in   (right_in),
    .sample_in  (sample_in),
    .gain_wr    (gain_wr),
    .gain_addr  (gain_addr),
    .gain_din   (gain_din),
    .ovr_clr    (ovr_clr),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .snd_sample (snd_sample),
    .busy       (busy),
    .overrun    (overrun)
`ifdef JT12_MIXN_CLIP_EN
    ,
    .clip_left  (clip_left),
    .clip_right (clip_right)
`endif
  );

  jt12_mixn #(.CH(3), .W(16), .GW(8), .OW(16)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .cen        (b_cen),
    .left_in    (b_left_in),
    .right_in   (b_right_in),
    .sample_in  (b_sample_in),
    .gain_wr    (b_gain_wr),
    .gain_addr  (b_gain_addr),
    .gain_din   (b_gain_din),
    .ovr_clr    (b_ovr_clr),
    .snd_left   (b_snd_left),
    .snd_right  (b_snd_right),
    .snd_sample (b_snd_sample),
    .busy       (b_busy),
    .overrun    (b_overrun)
`ifdef JT12_MIXN_CLIP_EN
    ,
    .clip_left  (b_clip_left),
    .clip_right (b_clip_right)
`endif
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] gm[4];

  typedef struct {
    logic [63:0]        l;
    logic [63:0]        r;
    logic [31:0]        g;
    logic signed [15:0] el;
    logic signed [15:0] er;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gain(input int a, input logic [7:0] v);
    gain_addr = a[1:0];
    gain_din  = v;
    gain_wr   = 1'b1;
    tick();
    gain_wr   = 1'b0;
    if (a < 4) gm[a] = v;
  endtask

  // mix = floor(sum(sample*gain) / 128), clamped to 16-bit signed
  function automatic longint model(input logic [63:0] s);
    longint acc = 0;
    longint q;
    for (int k = 0; k < 4; k++)
      acc += longint'($signed(s[k*16 +: 16])) * longint'(gm[k]);
    q = acc / 128;
    if ((acc % 128 != 0) && (acc < 0)) q--;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic mix(input logic [63:0] lp, input logic [63:0] rp,
                     input int p, output logic signed [15:0] ol,
                     output logic signed [15:0] orr, output int ncen,
                     output int nbusy, output bit ok);
    left_in   = lp;
    right_in  = rp;
    cen       = 1'b1;
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    ncen  = 0;
    nbusy = busy ? 1 : 0;
    ok    = 1'b0;
    ol    = '0;
    orr   = '0;
    for (int c = 1; c < 200 && !ok; c++) begin
      cen = (c % p == 0);
      tick();
      if (cen) ncen++;
      if (snd_sample) begin
        ok  = 1'b1;
        ol  = snd_left;
        orr = snd_right;
      end else if (busy) begin
        nbusy++;
      end
    end
    cen = 1'b1;
  endtask

  task automatic wait_snd(output logic signed [15:0] ol, output bit ok);
    ok = 1'b0;
    ol = '0;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick();
      if (snd_sample) begin
        ok = 1'b1;
        ol = snd_left;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] gl, gr;
    int                 nc, nb, seen;
    bit                 ok;
    logic [63:0]        rl, rr;

    rst = 1'b1; cen = 1'b1; sample_in = 1'b0; gain_wr = 1'b0;
    ovr_clr = 1'b0; left_in = '0; right_in = '0;
    gain_addr = '0; gain_din = '0;
    b_cen = 1'b1; b_sample_in = 1'b0; b_gain_wr = 1'b0; b_ovr_clr = 1'b0;
    b_left_in = '0; b_right_in = '0; b_gain_addr = '0; b_gain_din = '0;
    for (int k = 0; k < 4; k++) gm[k] = 8'h80;

    tv[0] = '{{16'sd0, -16'sd500, 16'sd2000, 16'sd1000}, 64'd0,
              {4{8'h80}}, 16'sd2500, 16'sd0};
    tv[1] = '{{4{16'sd32767}}, {4{16'h8000}},
              {4{8'h80}}, 16'sd32767, -16'sd32768};
    tv[2] = '{{48'd0, 16'sd1000}, {48'd0, -16'sd1000},
              {24'h808080, 8'h40}, 16'sd500, -16'sd500};
    tv[3] = '{{48'd0, 16'sd1000}, {48'd0, -16'sd1000},
              {24'h808080, 8'h00}, 16'sd0, 16'sd0};
    tv[4] = '{{48'd0, 16'sd1000}, {48'd0, -16'sd1000},
              {24'h808080, 8'hFF}, 16'sd1992, -16'sd1993};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_snd_left", snd_left, 0);
    chk("rst_snd_right", snd_right, 0);
    chk("rst_snd_sample", snd_sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
`ifdef JT12_MIXN_CLIP_EN
    chk("rst_clip_left", clip_left, 0);
`endif

    // CH=3 instance: out-of-range gain address must be ignored
    b_gain_addr = 2'd3; b_gain_din = 8'h00; b_gain_wr = 1'b1;
    tick();
    b_gain_wr = 1'b0;
    b_left_in = {3{16'sd1000}};
    b_sample_in = 1'b1;
    tick();
    b_sample_in = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (b_snd_sample) seen = c + 1;
    end
    chk("ch3_latency", seen, 4);
    chk("ch3_addr_oob", b_snd_left, 3000);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) set_gain(k, tv[i].g[k*8 +: 8]);
      mix(tv[i].l, tv[i].r, 1, gl, gr, nc, nb, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_left", i), gl, tv[i].el);
      chk($sformatf("vec%0d_right", i), gr, tv[i].er);
      chk($sformatf("vec%0d_cen", i), nc, 5);
      if (i == 0) chk("vec0_busy_cycles", nb, 5);
    end
`ifdef JT12_MIXN_CLIP_EN
    chk("clip_left_set", clip_left, 1);
    chk("clip_right_set", clip_right, 1);
`endif

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) set_gain(k, 8'($urandom));
      rl = {$urandom, $urandom};
      rr = {$urandom, $urandom};
      mix(rl, rr, $urandom_range(1, 3), gl, gr, nc, nb, ok);
      chk($sformatf("rnd%0d_done", i), ok, 1);
      chk($sformatf("rnd%0d_left", i), gl, model(rl));
      chk($sformatf("rnd%0d_right", i), gr, model(rr));
      chk($sformatf("rnd%0d_cen", i), nc, 5);
    end

    // overrun: second sample two cycles into a mix is dropped
    for (int k = 0; k < 4; k++) set_gain(k, 8'h80);
    left_in = tv[0].l; right_in = '0;
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    tick();
    left_in = tv[1].l;
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    wait_snd(gl, ok);
    chk("ovr_done", ok, 1);
    chk("ovr_first_mix_kept", gl, 2500);
    chk("ovr_flag_set", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    tick();
    sample_in = 1'b1; ovr_clr = 1'b1;
    tick();
    sample_in = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    wait_snd(gl, ok);
    chk("ovr2_done", ok, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;

    // gain write during accumulation affects only the next sample
    left_in = {48'd0, 16'sd1000};
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    set_gain(0, 8'h40);
    wait_snd(gl, ok);
    chk("gwr_current", gl, 1000);
    mix({48'd0, 16'sd1000}, 64'd0, 1, gl, gr, nc, nb, ok);
    chk("gwr_next", gl, 500);

    // slow clock enable, one of three cycles
    set_gain(0, 8'h80);
    mix(tv[0].l, 64'd0, 3, gl, gr, nc, nb, ok);
    chk("cen3_left", gl, 2500);
    chk("cen3_count", nc, 5);

    // reset mid-mix aborts and restores unity gains
    set_gain(0, 8'h40);
    left_in = {48'd0, 16'sd1000};
    sample_in = 1'b1;
    tick();
    sample_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) gm[k] = 8'h80;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (snd_sample) seen++;
      tick();
    end
    chk("rst_abort_no_sample", seen, 0);
    chk("rst_abort_left", snd_left, 0);
    chk("rst_abort_busy", busy, 0);
    mix({48'd0, 16'sd1000}, 64'd0, 1, gl, gr, nc, nb, ok);
    chk("rst_gain_unity", gl, model({48'd0, 16'sd1000}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
